// File: rtl/lut_multiplier_seq_if.sv
// Start/done handshake bundle for the sequential LUT multiplier.
// The requester drives the operands and start; the multiplier returns busy, done and the product.
interface lut_multiplier_seq_if #(
    parameter int A_WIDTH = 16,
    parameter int B_WIDTH = 16
);
    logic                       start;
    logic                       reuse_a;
    logic [A_WIDTH-1:0]         A;
    logic [B_WIDTH-1:0]         B;
    logic                       busy;
    logic                       done;
    logic [A_WIDTH+B_WIDTH-1:0] M;

    modport master (
        output start, reuse_a, A, B,
        input  busy, done, M
    );

    modport slave (
        input  start, reuse_a, A, B,
        output busy, done, M
    );
endinterface

// File: rtl/lut_multiplier_seq.sv
// Sequential LUT multiplier: builds a table of multiples of A (one entry per clock),
// then accumulates B one DIGIT-wide digit per clock, most significant digit first.
// The table can be kept across operations so repeated multiplies by the same A skip the build.
module lut_multiplier_seq #(
    parameter int A_WIDTH = 16,
    parameter int B_WIDTH = 16,
    parameter int DIGIT   = 4
) (
    input logic                 clk,
    input logic                 reset,
    lut_multiplier_seq_if.slave bus
);
    localparam int N     = B_WIDTH / DIGIT;
    localparam int P_W   = A_WIDTH + B_WIDTH;
    localparam int T     = 2 ** DIGIT;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUILD, S_ACCUM, S_DONE} state_t;

    state_t             state_q;
    logic               busy_q;
    logic               done_q;
    logic               tv_q;
    logic [P_W-1:0]     m_q;
    logic [P_W-1:0]     acc_q;
    logic [P_W-1:0]     acc_d;
    logic [P_W-1:0]     a_q;
    logic [P_W-1:0]     entry_d;
    logic [B_WIDTH-1:0] b_q;
    logic [IDX_W-1:0]   idx_q;
    logic [DIGIT-1:0]   bk_q;
    logic [DIGIT-1:0]   digit;
    logic [P_W-1:0]     tbl_q [T];
    logic               accept;
    logic               rebuild;

    // Handshake decode and the two datapath adders (table build and digit accumulate).
    always_comb begin
        accept  = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
        rebuild = !(bus.reuse_a && tv_q);
        // b_q is shifted left each ACCUM step, so the current digit is always the top slice.
        digit   = b_q[B_WIDTH-1 -: DIGIT];
        acc_d   = (acc_q << DIGIT) + tbl_q[digit];
        entry_d = tbl_q[bk_q - DIGIT'(1)] + a_q;
    end

    // Control FSM with registered busy/done/product; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            m_q     <= '0;
            tv_q    <= 1'b0;
            acc_q   <= '0;
            idx_q   <= '0;
            bk_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    busy_q <= 1'b0;
                    if (accept) begin
                        acc_q  <= '0;
                        idx_q  <= IDX_W'(N - 1);
                        busy_q <= 1'b1;
                        if (rebuild) begin
                            // Table is being overwritten, so it is not usable until BUILD finishes.
                            tv_q    <= 1'b0;
                            bk_q    <= DIGIT'(2);
                            state_q <= S_BUILD;
                        end else begin
                            state_q <= S_ACCUM;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_BUILD: begin
                    bk_q <= bk_q + DIGIT'(1);
                    if (bk_q == DIGIT'(T - 1)) begin
                        tv_q    <= 1'b1;
                        state_q <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q - IDX_W'(1);
                    if (idx_q == '0) begin
                        m_q     <= acc_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Operand latches and multiples table; contents are only trusted once tv_q says so.
    always_ff @(posedge clk) begin
        if (accept) begin
            b_q <= bus.B;
            if (rebuild) begin
                a_q      <= {{B_WIDTH{1'b0}}, bus.A};
                tbl_q[0] <= '0;
                tbl_q[1] <= {{B_WIDTH{1'b0}}, bus.A};
            end
        end else if (state_q == S_BUILD) begin
            tbl_q[bk_q] <= entry_d;
        end else if (state_q == S_ACCUM) begin
            b_q <= b_q << DIGIT;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.M    = m_q;
endmodule

// File: tb/tb_lut_multiplier_seq.sv
// Bench for lut_multiplier_seq: directed handshake/latency cases on the default
// configuration, plus randomized operations on several DIGIT/B_WIDTH variants
// checked against a plain-arithmetic product and latency model.
module tb_lut_multiplier_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    lut_multiplier_seq_if #(.A_WIDTH(16), .B_WIDTH(16)) mb ();
    lut_multiplier_seq #(.A_WIDTH(16), .B_WIDTH(16), .DIGIT(4)) u_dut (
        .clk   (clk),
        .reset (rst),
        .bus   (mb)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic ru);
        mb.A       = a;
        mb.B       = b;
        mb.reuse_a = ru;
        mb.start   = 1'b1;
        @(posedge clk); #1;
        mb.start   = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        while (!mb.done && lat < 200) begin
            if (mb.busy) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
        if (!mb.done) chk("timeout", 64'd0, 64'd1);
    endtask

    // Extra configurations running randomized operations concurrently.
    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int DG = (g == 0) ? 2 : ((g == 1) ? 3 : 4);
        localparam int BW = (g == 0) ? 12 : 24;
        logic rg  = 1'b1;
        bit   fin = 1'b0;
        lut_multiplier_seq_if #(.A_WIDTH(16), .B_WIDTH(BW)) bus ();
        lut_multiplier_seq #(.A_WIDTH(16), .B_WIDTH(BW), .DIGIT(DG)) dut (
            .clk   (clk),
            .reset (rg),
            .bus   (bus)
        );

        initial begin
            logic [15:0]     na;
            logic [BW-1:0]   nb;
            logic            ru;
            bit              tv;
            longint unsigned ma, prev;
            int              lat, el;
            bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.reuse_a = 1'b0;
            rg = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            chk("g_rst_m", 64'(bus.M), 64'd0);
            rg = 1'b0;
            tv = 1'b0; ma = 0; prev = 0;
            for (int i = 0; i < 250; i++) begin
                na = 16'($urandom);
                nb = BW'($urandom);
                ru = 1'($urandom);
                if (!(ru && tv)) begin
                    ma = longint'(na);
                    el = (2 ** DG - 2) + BW / DG;
                end else begin
                    el = BW / DG;
                end
                bus.A = na; bus.B = nb; bus.reuse_a = ru; bus.start = 1'b1;
                @(posedge clk); #1;
                chk("g_hold", 64'(bus.M), prev);
                lat = 0;
                while (!bus.done && lat < 200) begin
                    bus.start   = 1'($urandom);
                    bus.A       = 16'($urandom);
                    bus.B       = BW'($urandom);
                    bus.reuse_a = 1'($urandom);
                    @(posedge clk); #1;
                    lat++;
                end
                bus.start = 1'b0;
                chk("g_lat", 64'(lat), 64'(el));
                chk("g_m", 64'(bus.M), ma * 64'(nb));
                prev = ma * 64'(nb);
                tv = 1'b1;
                if ($urandom % 3 == 0) begin
                    @(posedge clk); #1;
                end
            end
            fin = 1'b1;
        end
    end

    initial begin
        int              lat, nb, cnt, w;
        logic [15:0]     ra, rb;
        logic            ru;
        bit              tv;
        longint unsigned ma, prev;
        mb.start = 1'b0; mb.A = '0; mb.B = '0; mb.reuse_a = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(mb.busy), 64'd0);
        chk("rst_done", 64'(mb.done), 64'd0);
        chk("rst_m", 64'(mb.M), 64'd0);
        rst = 1'b0;

        // Basic op with busy window.
        start_op(16'd3, 16'd5, 1'b0);
        chk("t1_hold", 64'(mb.M), 64'd0);
        wait_done(lat, nb);
        chk("t1_lat", 64'(lat), 64'd18);
        chk("t1_m", 64'(mb.M), 64'd15);
        chk("t1_busy", 64'(nb), 64'd18);
        @(posedge clk); #1;
        chk("t1_done_low", 64'(mb.done), 64'd0);
        chk("t1_m_held", 64'(mb.M), 64'd15);

        // Full-scale operands, then table reuse with a different A on the bus.
        start_op(16'hFFFF, 16'hFFFF, 1'b0);
        wait_done(lat, nb);
        chk("t2_lat", 64'(lat), 64'd18);
        chk("t2_m", 64'(mb.M), 64'hFFFE0001);
        start_op(16'h1234, 16'd2, 1'b1);
        wait_done(lat, nb);
        chk("t2_reuse_lat", 64'(lat), 64'd4);
        chk("t2_reuse_m", 64'(mb.M), 64'h0001FFFE);

        // Reuse requested right after reset must rebuild.
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        start_op(16'd7, 16'd9, 1'b1);
        wait_done(lat, nb);
        chk("t3_lat", 64'(lat), 64'd18);
        chk("t3_m", 64'(mb.M), 64'd63);

        // Reset in the middle of BUILD.
        start_op(16'd100, 16'd100, 1'b0);
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b1; @(posedge clk); #1;
        chk("t4_busy", 64'(mb.busy), 64'd0);
        chk("t4_m", 64'(mb.M), 64'd0);
        rst = 1'b0;
        cnt = 0;
        repeat (20) begin @(posedge clk); #1; if (mb.done) cnt++; end
        chk("t4_no_done", 64'(cnt), 64'd0);
        start_op(16'd5, 16'd6, 1'b1);
        wait_done(lat, nb);
        chk("t4_lat", 64'(lat), 64'd18);
        chk("t4_m", 64'(mb.M), 64'd30);

        // Start pulse while busy is ignored; start in DONE begins the next op.
        start_op(16'd10, 16'd11, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        mb.A = 16'd2; mb.B = 16'd2; mb.start = 1'b1;
        @(posedge clk); #1;
        mb.start = 1'b0;
        wait_done(lat, nb);
        chk("t5_lat", 64'(lat + 4), 64'd18);
        chk("t5_m", 64'(mb.M), 64'd110);
        start_op(16'd4, 16'd5, 1'b0);
        chk("t5_single_done", 64'(mb.done), 64'd0);
        chk("t5_b2b_busy", 64'(mb.busy), 64'd1);
        wait_done(lat, nb);
        chk("t5_b2b_lat", 64'(lat), 64'd18);
        chk("t5_b2b_m", 64'(mb.M), 64'd20);

        // Zero operands keep full latency.
        start_op(16'd0, 16'hABCD, 1'b0);
        wait_done(lat, nb);
        chk("z_lat", 64'(lat), 64'd18);
        chk("z_m", 64'(mb.M), 64'd0);
        start_op(16'hFFFF, 16'd0, 1'b1);
        wait_done(lat, nb);
        chk("z_reuse_lat", 64'(lat), 64'd4);
        chk("z_reuse_m", 64'(mb.M), 64'd0);

        // Randomized ops on the default configuration; table holds A=0 at this point.
        tv = 1'b1; ma = 0; prev = 0;
        for (int i = 0; i < 250; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            ru = 1'($urandom);
            if (!(ru && tv)) ma = longint'(ra);
            start_op(ra, rb, ru);
            chk("r_hold", 64'(mb.M), prev);
            wait_done(lat, nb);
            chk("r_lat", 64'(lat), (ru && tv) ? 64'd4 : 64'd18);
            chk("r_m", 64'(mb.M), ma * 64'(rb));
            prev = ma * 64'(rb);
            tv = 1'b1;
            if ($urandom % 4 == 0) begin
                @(posedge clk); #1;
            end
        end

        w = 0;
        while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) && w < 60000) begin
            @(posedge clk);
            w++;
        end
        if (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin)) chk("gen_timeout", 64'd0, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
